// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader: FSM state encoding,
// default memory geometry and the number of serial bytes per instruction.
package loader_pkg;

   localparam int unsigned ADDR_W_DEF     = 12;
   localparam int unsigned INSTR_W_DEF    = 19;
   localparam int unsigned BYTES_PER_WORD = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_B2,
      ST_WRITE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/instr_assembler.sv
// Captures three little-endian serial bytes into one instruction word and
// flags a format error when the top byte carries bits beyond the word width.
module instr_assembler
   import loader_pkg::*;
#(
   parameter int unsigned INSTR_W = INSTR_W_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cap_en,
   input  logic [1:0]         byte_idx,
   input  logic [7:0]         in_data,
   output logic [INSTR_W-1:0] word,
   output logic               fmt_bad
);

   localparam int unsigned HI_W = INSTR_W - 16;
   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [7:0]      byte0_q;
   logic [7:0]      byte1_q;
   logic [HI_W-1:0] hi_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte0_q <= '0;
         byte1_q <= '0;
         hi_q    <= '0;
      end else if (cap_en) begin
         case (byte_idx)
            2'd0:    byte0_q <= in_data;
            2'd1:    byte1_q <= in_data;
            default: hi_q    <= in_data[HI_W-1:0];
         endcase
      end
   end

   assign word    = {hi_q, byte1_q, byte0_q};
   // Upper bits of the last byte are dropped from the word but reported.
   assign fmt_bad = cap_en && (byte_idx == LAST_IDX) && (in_data[7:HI_W] != '0);

endmodule

// File: rtl/program_loader.sv
// Serial-to-instruction-memory loader: accepts a byte stream, assembles
// 3-byte instructions and writes them to consecutive addresses.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    word_count,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic              err_q;
   logic              accept;
   logic              xfer;
   logic              fmt_bad;
   logic [1:0]        byte_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      accept   = 1'b0;
      byte_idx = 2'd0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept  = 1'b1;
               state_d = (word_count == '0) ? ST_DONE : ST_B0;
            end
         end
         ST_B0: begin
            in_ready = 1'b1;
            byte_idx = 2'd0;
            if (in_valid) state_d = ST_B1;
         end
         ST_B1: begin
            in_ready = 1'b1;
            byte_idx = 2'd1;
            if (in_valid) state_d = ST_B2;
         end
         ST_B2: begin
            in_ready = 1'b1;
            byte_idx = 2'd2;
            if (in_valid) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            wr_en   = 1'b1;
            // count_q still holds the pre-decrement value here.
            state_d = (count_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_B0;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign xfer = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= base_addr;
            count_q <= word_count;
            err_q   <= 1'b0;
         end else if (wr_en) begin
            addr_q  <= addr_q + ADDR_W'(1);
            count_q <= count_q - (ADDR_W+1)'(1);
         end
         if (fmt_bad) err_q <= 1'b1;
      end
   end

   instr_assembler #(
      .INSTR_W (INSTR_W)
   ) u_asm (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (xfer),
      .byte_idx (byte_idx),
      .in_data  (in_data),
      .word     (wr_data),
      .fmt_bad  (fmt_bad)
   );

   assign wr_addr = addr_q;
   assign err     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads plus hand
// sequences for empty load, mid-load reset and stalled/noisy streams.
module tb_program_loader;

   localparam int unsigned AW = 12;
   localparam int unsigned IW = 19;

   typedef struct {
      logic [AW-1:0]         base;
      logic [AW:0]           cnt;
      logic [5:0][7:0]       b;
      logic [1:0][IW-1:0]    w;
      logic                  err;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_count = '0;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [IW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic prev_wr    = 1'b0;
   logic track_busy = 1'b0;
   logic busy_drop  = 1'b0;

   logic [AW-1:0] exp_addr_q[$];
   logic [IW-1:0] exp_data_q[$];
   vec_t vecs[4];

   program_loader #(
      .ADDR_W  (AW),
      .INSTR_W (IW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   // Write scoreboard: every strobe must match the next expected write.
   always @(negedge clk) begin
      if (rst && wr_en) begin
         check("wr_en_single_cycle", prev_wr, 0);
         check("wr_en_vs_in_ready", in_ready, 0);
         if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", wr_addr, wr_data);
         end else begin
            check("wr_addr", wr_addr, exp_addr_q.pop_front());
            check("wr_data", wr_data, exp_data_q.pop_front());
         end
      end
      prev_wr = wr_en;
      if (track_busy && !busy) busy_drop = 1'b1;
   end

   task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] c);
      @(negedge clk);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, required 1", n);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL done_timeout: got done=0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int t0;
      for (int i = 0; i < v.cnt; i++) begin
         exp_addr_q.push_back(v.base + AW'(i));
         exp_data_q.push_back(v.w[i]);
      end
      start_load(v.base, v.cnt);
      check("err_clear_on_start", err, 0);
      check("busy_after_start", busy, 1);
      busy_drop  = 1'b0;
      track_busy = 1'b1;
      t0 = cyc;
      for (int i = 0; i < v.cnt * 3; i++) send_byte(v.b[i]);
      in_valid = 1'b0;
      wait_done();
      track_busy = 1'b0;
      check("load_latency", cyc - t0, 4 * v.cnt);
      check("busy_until_done", busy_drop, 0);
      check("writes_complete", exp_addr_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_not_busy", busy, 0);
      check("err_hold", err, v.err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]    rb[15];
      logic [IW-1:0] w;
      logic          r_err;
      vec_t          rv;

      vecs[0] = '{12'h001, 13'd1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h40}, {19'h0, 19'h00940}, 1'b0};
      vecs[1] = '{12'hFFF, 13'd2, {8'h00, 8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF}, {19'h00001, 19'h7FFFF}, 1'b0};
      vecs[2] = '{12'h123, 13'd1, {8'h00, 8'h00, 8'h00, 8'hF9, 8'h55, 8'hAA}, {19'h0, 19'h155AA}, 1'b1};
      vecs[3] = '{12'h800, 13'd2, {8'h03, 8'hDC, 8'hFE, 8'h05, 8'h34, 8'h12}, {19'h3DCFE, 19'h53412}, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Empty load: straight to DONE, no byte accepted
      in_valid = 1'b1;
      in_data  = 8'h55;
      start_load(12'h055, 13'd0);
      check("cnt0_done", done, 1);
      check("cnt0_busy", busy, 1);
      check("cnt0_in_ready", in_ready, 0);
      @(negedge clk);
      check("cnt0_done_end", done, 0);
      check("cnt0_busy_end", busy, 0);
      check("cnt0_in_ready_end", in_ready, 0);
      in_valid = 1'b0;

      // Reset after two bytes of a word
      start_load(12'h200, 13'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 0);
      check("midrst_wr_en", wr_en, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_err", err, 0);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_wr_data", wr_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rv = '{12'h200, 13'd1, {8'h00, 8'h00, 8'h00, 8'h03, 8'h02, 8'h01}, {19'h0, 19'h30201}, 1'b0};
      run_vec(rv);

      // Stalled stream with start pulses while busy
      r_err = 1'b0;
      for (int i = 0; i < 15; i++) rb[i] = 8'($urandom);
      for (int k = 0; k < 5; k++) begin
         w = {rb[3*k+2][2:0], rb[3*k+1], rb[3*k]};
         exp_addr_q.push_back(12'h7FE + AW'(k));
         exp_data_q.push_back(w);
         r_err = r_err | (rb[3*k+2][7:3] != 5'd0);
      end
      start_load(12'h7FE, 13'd5);
      for (int i = 0; i < 15; i++) begin
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
            in_valid   = 1'b0;
            in_data    = 8'($urandom);
            start      = ($urandom_range(0, 1) == 0);
            base_addr  = 12'h000;
            word_count = 13'd1;
            @(negedge clk);
            start = 1'b0;
         end
         send_byte(rb[i]);
      end
      in_valid = 1'b0;
      wait_done();
      check("rand_writes_complete", exp_addr_q.size(), 0);
      check("rand_err", err, r_err);
      @(negedge clk);
      check("rand_idle_after_done", busy, 0);
      repeat (4) @(negedge clk);
      check("rand_no_extra_writes", exp_addr_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory address width.
REQ-002 Parameter INSTR_W, default 19, instruction word width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first memory address written; latched on accepted start.
REQ-008 word_count  in  ADDR_W+1  number of words to load (0..4096); latched on accepted start.
REQ-009 in_data  in  8  serial program byte.
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready at clk edge.
REQ-012 wr_en  out  1  one-cycle instruction-memory write strobe.
REQ-013 wr_addr  out  ADDR_W  write address, valid when wr_en=1.
REQ-014 wr_data  out  INSTR_W  assembled instruction, valid when wr_en=1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when load completes.
REQ-017 err  out  1  sticky format error; cleared on next accepted start.

Function
REQ-018 States: IDLE, B0, B1, B2, WRITE, DONE.
REQ-019 IDLE: start=1 latches base_addr and word_count, clears err, and goes to B0, or to DONE if word_count=0; start in any other state is ignored.
REQ-020 in_ready=1 only in B0, B1 and B2; it is 0 in IDLE, WRITE and DONE.
REQ-021 Byte order: little-endian. B0 captures bits [7:0], B1 captures [15:8], B2 captures [18:16] from in_data[2:0]. Each state advances only on a transfer.
REQ-022 In B2, if in_data[7:3] is non-zero, err is set; the word is still written with those bits dropped.
REQ-023 WRITE lasts exactly one cycle with wr_en=1, wr_addr=current address and wr_data=assembled word. wr_en rises in the cycle after the third byte is accepted.
REQ-024 After WRITE: the address increments modulo 2^ADDR_W (4095 wraps to 0) and the remaining count decrements. The next state is B0 if the remaining count is non-zero, else DONE.
REQ-025 DONE lasts one cycle with done=1, then returns to IDLE. err holds its value.
REQ-026 Minimum throughput: 4 cycles per word with in_valid held high.
REQ-027 When wr_en=0, wr_addr and wr_data hold their last values; their content is don't-care.
REQ-028 Stalls: in_valid=0 in any B state holds that state indefinitely with no timeout.

Reset
REQ-029 rst=0 forces IDLE immediately, including mid-load. Outputs go to: in_ready=0, wr_en=0, busy=0, done=0, err=0, wr_addr=0, wr_data=0. The internal address, count and byte registers are cleared.
REQ-030 A partially assembled word is discarded on reset and never written.

Structure
REQ-031 Package loader_pkg holds the state enum typedef, the ADDR_W and INSTR_W defaults, and the byte count per word (3).
REQ-032 One sub-module, instr_assembler, holds the 3-byte shift/capture logic and the format check. The FSM, address counter and word counter stay in program_loader.

Verification
REQ-033 start, base=0x001, count=1; bytes 0x40,0x09,0x00 with in_valid held high -> wr_en one cycle, wr_addr=0x001, wr_data=19'h00940; done one cycle later; err=0.
REQ-034 start, base=0xFFF, count=2; words 0x7FFFF then 0x00001 (bytes FF,FF,07 / 01,00,00) -> writes go to 0xFFF then 0x000 with the correct data; busy stays high until done.
REQ-035 start, count=0 -> no wr_en, in_ready stays 0, done pulses in the cycle after start, busy high for exactly one cycle.
REQ-036 Third byte 0xF9 -> wr_data[18:16]=3'b001, err=1 until the next start, which clears it.
REQ-037 rst=0 asserted after two bytes of a word -> immediate IDLE, all outputs at reset values, no write. A new load after reset writes the correct data.
REQ-038 in_valid toggled randomly, with start pulses injected mid-load -> data matches a reference model, start is ignored while busy, and wr_en never coincides with in_ready.
